// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (core/ext) round-robin arbiter onto a shared single-port memory
// Optional MEM_ARB_LOCK_EN adds i_ext_lock and a lock FSM that gives ext exclusive access.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
`ifdef MEM_ARB_LOCK_EN
    input  logic              i_ext_lock,
`endif
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [DATA_W-1:0] i_ext_wdata,
    output logic              o_ext_gnt,
    output logic              o_ext_rvalid,
    output logic [DATA_W-1:0] o_ext_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wd,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rd
);

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_EXT  = 1'b1;

    logic              r_last_grant;
    logic              r_core_rvalid;
    logic              r_ext_rvalid;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_ext_rdata;

    logic              w_locked;
    logic              w_core_gnt;
    logic              w_ext_gnt;
    logic              w_core_acc;
    logic              w_ext_acc;

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t r_lock_state;

    // Idle ext (req low) always releases the lock so a vanished owner cannot starve the core.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_state <= ST_UNLOCKED;
        end else begin
            case (r_lock_state)
                ST_UNLOCKED: begin
                    if (w_ext_acc && i_ext_lock) begin
                        r_lock_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!i_ext_req || (w_ext_acc && !i_ext_lock)) begin
                        r_lock_state <= ST_UNLOCKED;
                    end
                end
                default: r_lock_state <= ST_UNLOCKED;
            endcase
        end
    end

    assign w_locked = (r_lock_state == ST_LOCKED);
`else
    assign w_locked = 1'b0;
`endif

    // Grants are combinational in the request cycle and forced low while reset is held.
    always_comb begin
        w_core_gnt = 1'b0;
        w_ext_gnt  = 1'b0;
        if (i_rst_n) begin
            if (w_locked) begin
                w_ext_gnt = i_ext_req;
            end else if (i_core_req && i_ext_req) begin
                if (r_last_grant == GNT_EXT) begin
                    w_core_gnt = 1'b1;
                end else begin
                    w_ext_gnt = 1'b1;
                end
            end else begin
                w_core_gnt = i_core_req;
                w_ext_gnt  = i_ext_req;
            end
        end
    end

    assign w_core_acc = i_core_req && w_core_gnt;
    assign w_ext_acc  = i_ext_req && w_ext_gnt;

    always_comb begin
        o_mem_addr = '0;
        o_mem_wd   = '0;
        o_mem_we   = 1'b0;
        if (w_core_gnt) begin
            o_mem_addr = i_core_addr;
            o_mem_wd   = i_core_wdata;
            o_mem_we   = i_core_we;
        end else if (w_ext_gnt) begin
            o_mem_addr = i_ext_addr;
            o_mem_wd   = i_ext_wdata;
            o_mem_we   = i_ext_we;
        end
    end

    // Reset favours the core on the first tie by pretending ext won last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= GNT_EXT;
        end else if (w_core_acc) begin
            r_last_grant <= GNT_CORE;
        end else if (w_ext_acc) begin
            r_last_grant <= GNT_EXT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_core_rvalid <= 1'b0;
            r_core_rdata  <= '0;
        end else begin
            r_core_rvalid <= w_core_acc && !i_core_we;
            if (w_core_acc && !i_core_we) begin
                r_core_rdata <= i_mem_rd;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ext_rvalid <= 1'b0;
            r_ext_rdata  <= '0;
        end else begin
            r_ext_rvalid <= w_ext_acc && !i_ext_we;
            if (w_ext_acc && !i_ext_we) begin
                r_ext_rdata <= i_mem_rd;
            end
        end
    end

    assign o_core_gnt    = w_core_gnt;
    assign o_ext_gnt     = w_ext_gnt;
    assign o_core_rvalid = r_core_rvalid;
    assign o_core_rdata  = r_core_rdata;
    assign o_ext_rvalid  = r_ext_rvalid;
    assign o_ext_rdata   = r_ext_rdata;

endmodule
